// File: rtl/mem_arbiter_if.sv
// Requester and RAM signal bundle for mem_arbiter. The arbiter uses the slave
// modport; the requesters and the RAM model use master.
interface mem_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned MEM_AW     = 12
);
  logic                  m0_req_i;
  logic                  m0_we_i;
  logic [ADDR_WIDTH-1:0] m0_addr_i;
  logic [DATA_WIDTH-1:0] m0_wdata_i;
  logic                  m0_ack_o;
  logic [DATA_WIDTH-1:0] m0_rdata_o;

  logic                  m1_req_i;
  logic                  m1_we_i;
  logic [ADDR_WIDTH-1:0] m1_addr_i;
  logic [DATA_WIDTH-1:0] m1_wdata_i;
  logic                  m1_ack_o;
  logic [DATA_WIDTH-1:0] m1_rdata_o;

  logic [MEM_AW-1:0]     mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic                  mem_we_o;
  logic [DATA_WIDTH-1:0] mem_rdata_i;
  logic [1:0]            grant_o;

  modport slave (
    input  m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i,
    output m0_ack_o, m0_rdata_o,
    input  m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i,
    output m1_ack_o, m1_rdata_o,
    output mem_addr_o, mem_wdata_o, mem_we_o, grant_o,
    input  mem_rdata_i
  );

  modport master (
    output m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i,
    input  m0_ack_o, m0_rdata_o,
    output m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i,
    input  m1_ack_o, m1_rdata_o,
    input  mem_addr_o, mem_wdata_o, mem_we_o, grant_o,
    output mem_rdata_i
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer for a single-port synchronous RAM with a
// registered read. Each access runs IDLE -> ACCESS -> RESP -> IDLE.
module mem_arbiter #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned MEM_AW     = 12,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [MEM_AW-1:0]     addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  we_q, we_d;
  logic [1:0]            grant_q, grant_d;
  logic [1:0]            ack_q, ack_d;
  logic                  last_q, last_d;   // 1 = port 1 was granted last

  logic                  pick0, pick1;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  sel_we;

  // Upper requester address bits are dropped on purpose.
  if (ADDR_WIDTH > MEM_AW) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^sel_addr[ADDR_WIDTH-1:MEM_AW];
  end

  // Next-state, arbitration and registered-output computation.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    grant_d = grant_q;
    last_d  = last_q;
    ack_d   = 2'b00;

    pick0     = bus.m0_req_i & (~bus.m1_req_i | FIXED_PRIO | last_q);
    pick1     = bus.m1_req_i & ~pick0;
    sel_addr  = pick1 ? bus.m1_addr_i  : bus.m0_addr_i;
    sel_wdata = pick1 ? bus.m1_wdata_i : bus.m0_wdata_i;
    sel_we    = pick1 ? bus.m1_we_i    : bus.m0_we_i;

    unique case (state_q)
      IDLE: begin
        if (pick0 | pick1) begin
          state_d = ACCESS;
          addr_d  = sel_addr[MEM_AW-1:0];
          wdata_d = sel_wdata;
          we_d    = sel_we;
          grant_d = {pick1, pick0};
          last_d  = pick1;
        end
      end
      ACCESS: begin
        state_d = RESP;
        we_d    = 1'b0;
        ack_d   = grant_q;
      end
      RESP: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      grant_q <= 2'b00;
      ack_q   <= 2'b00;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      last_q  <= last_d;
    end
  end

  assign bus.mem_addr_o  = addr_q;
  assign bus.mem_wdata_o = wdata_q;
  assign bus.mem_we_o    = we_q;
  assign bus.grant_o     = grant_q;
  assign bus.m0_ack_o    = ack_q[0];
  assign bus.m1_ack_o    = ack_q[1];

  // RAM read data reaches only the owner, and only during its ack cycle.
  assign bus.m0_rdata_o  = ack_q[0] ? bus.mem_rdata_i : '0;
  assign bus.m1_rdata_o  = ack_q[1] ? bus.mem_rdata_i : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter: dut0 uses round-robin, dut1 fixed priority,
// each with its own RAM model (registered read, one-cycle latency).
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .MEM_AW(12)) bus0 ();
  mem_arbiter_if #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .MEM_AW(12)) bus1 ();

  mem_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .MEM_AW(12), .FIXED_PRIO(1'b0))
    dut0 (.clk_i(clk), .rst_i(rst), .bus(bus0));
  mem_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .MEM_AW(12), .FIXED_PRIO(1'b1))
    dut1 (.clk_i(clk), .rst_i(rst), .bus(bus1));

  logic [15:0] ram0 [0:4095];
  logic [15:0] ram1 [0:4095];

  always @(posedge clk) begin
    if (bus0.mem_we_o) ram0[bus0.mem_addr_o] <= bus0.mem_wdata_o;
    bus0.mem_rdata_i <= ram0[bus0.mem_addr_o];
    if (bus1.mem_we_o) ram1[bus1.mem_addr_o] <= bus1.mem_wdata_o;
    bus1.mem_rdata_i <= ram1[bus1.mem_addr_o];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    bus0.m0_req_i = 1'b0; bus0.m0_we_i = 1'b0; bus0.m0_addr_i = '0; bus0.m0_wdata_i = '0;
    bus0.m1_req_i = 1'b0; bus0.m1_we_i = 1'b0; bus0.m1_addr_i = '0; bus0.m1_wdata_i = '0;
    bus1.m0_req_i = 1'b0; bus1.m0_we_i = 1'b0; bus1.m0_addr_i = '0; bus1.m0_wdata_i = '0;
    bus1.m1_req_i = 1'b0; bus1.m1_we_i = 1'b0; bus1.m1_addr_i = '0; bus1.m1_wdata_i = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [32:0] obs;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      obs = {bus0.m0_ack_o, bus0.m1_ack_o, bus0.mem_we_o, bus0.grant_o,
             bus0.mem_addr_o, bus0.mem_wdata_o};
      total++;
      if (obs !== 33'd0) begin
        bad++;
        $display("FAIL reset_dut0 cycle %0d: got %h want 0", i, obs);
      end
      total++;
      if ({bus1.grant_o, bus1.mem_we_o, bus1.m0_ack_o, bus1.m1_ack_o} !== 5'd0) begin
        bad++;
        $display("FAIL reset_dut1 cycle %0d: grant=%b we=%b", i, bus1.grant_o, bus1.mem_we_o);
      end
      tick();
    end
  endtask

  task automatic test_write_read();
    bus0.m0_req_i = 1'b1; bus0.m0_we_i = 1'b1;
    bus0.m0_addr_i = 16'h0010; bus0.m0_wdata_i = 16'h1234;
    tick();
    total++;
    if ({bus0.mem_we_o, bus0.mem_addr_o, bus0.mem_wdata_o, bus0.grant_o, bus0.m0_ack_o}
        !== {1'b1, 12'h010, 16'h1234, 2'b01, 1'b0}) begin
      bad++;
      $display("FAIL wr_access: we=%b addr=%h wdata=%h grant=%b ack=%b want 1 010 1234 01 0",
               bus0.mem_we_o, bus0.mem_addr_o, bus0.mem_wdata_o, bus0.grant_o, bus0.m0_ack_o);
    end
    tick();
    total++;
    if ({bus0.mem_we_o, bus0.m0_ack_o, bus0.m1_ack_o} !== 3'b010) begin
      bad++;
      $display("FAIL wr_resp: we=%b ack0=%b ack1=%b want 0 1 0",
               bus0.mem_we_o, bus0.m0_ack_o, bus0.m1_ack_o);
    end
    bus0.m0_req_i = 1'b0;
    tick();
    total++;
    if ({bus0.m0_ack_o, bus0.grant_o, bus0.mem_we_o} !== 4'b0000) begin
      bad++;
      $display("FAIL wr_idle: ack0=%b grant=%b we=%b want 0", bus0.m0_ack_o, bus0.grant_o,
               bus0.mem_we_o);
    end
    bus0.m0_req_i = 1'b1; bus0.m0_we_i = 1'b0; bus0.m0_wdata_i = 16'h0000;
    tick();
    total++;
    if ({bus0.mem_we_o, bus0.grant_o, bus0.m0_ack_o} !== 4'b0010) begin
      bad++;
      $display("FAIL rd_access: we=%b grant=%b ack=%b want 0 01 0",
               bus0.mem_we_o, bus0.grant_o, bus0.m0_ack_o);
    end
    tick();
    total++;
    if ({bus0.m0_ack_o, bus0.m0_rdata_o, bus0.m1_rdata_o} !== {1'b1, 16'h1234, 16'h0000}) begin
      bad++;
      $display("FAIL rd_resp: ack=%b rdata0=%h rdata1=%h want 1 1234 0000",
               bus0.m0_ack_o, bus0.m0_rdata_o, bus0.m1_rdata_o);
    end
    bus0.m0_req_i = 1'b0;
    tick();
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g;
    do_reset();
    bus0.m0_req_i = 1'b1; bus0.m0_we_i = 1'b0; bus0.m0_addr_i = 16'h0010;
    bus0.m1_req_i = 1'b1; bus0.m1_we_i = 1'b1; bus0.m1_addr_i = 16'h0020;
    bus0.m1_wdata_i = 16'hBEEF;
    for (int i = 0; i < 4; i++) begin
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      tick();
      total++;
      if (bus0.grant_o !== exp_g) begin
        bad++;
        $display("FAIL rr_grant %0d: got %b want %b", i, bus0.grant_o, exp_g);
      end
      tick();
      total++;
      if ({bus0.m1_ack_o, bus0.m0_ack_o} !== exp_g) begin
        bad++;
        $display("FAIL rr_ack %0d: got %b%b want %b", i, bus0.m1_ack_o, bus0.m0_ack_o, exp_g);
      end
      if (i == 0) begin
        total++;
        if (bus0.m0_rdata_o !== 16'h1234) begin
          bad++;
          $display("FAIL rr_rdata0: got %h want 1234", bus0.m0_rdata_o);
        end
      end
      if (i == 3) begin
        bus0.m0_req_i = 1'b0;
        bus0.m1_req_i = 1'b0;
      end
      tick();
      total++;
      if ({bus0.grant_o, bus0.m0_ack_o, bus0.m1_ack_o} !== 4'b0000) begin
        bad++;
        $display("FAIL rr_idle %0d: grant=%b acks=%b%b want 0", i, bus0.grant_o,
                 bus0.m1_ack_o, bus0.m0_ack_o);
      end
    end
  endtask

  task automatic test_fixed_prio();
    do_reset();
    bus1.m0_req_i = 1'b1; bus1.m0_addr_i = 16'h0001;
    bus1.m1_req_i = 1'b1; bus1.m1_addr_i = 16'h0002;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (bus1.grant_o !== 2'b01) begin
        bad++;
        $display("FAIL fp_grant %0d: got %b want 01", i, bus1.grant_o);
      end
      tick();
      total++;
      if ({bus1.m1_ack_o, bus1.m0_ack_o} !== 2'b01) begin
        bad++;
        $display("FAIL fp_ack %0d: got %b%b want 01", i, bus1.m1_ack_o, bus1.m0_ack_o);
      end
      if (i == 2) bus1.m0_req_i = 1'b0;
      tick();
    end
    tick();
    total++;
    if (bus1.grant_o !== 2'b10) begin
      bad++;
      $display("FAIL fp_m1_grant: got %b want 10", bus1.grant_o);
    end
    tick();
    total++;
    if ({bus1.m1_ack_o, bus1.m0_ack_o} !== 2'b10) begin
      bad++;
      $display("FAIL fp_m1_ack: got %b%b want 10", bus1.m1_ack_o, bus1.m0_ack_o);
    end
    bus1.m1_req_i = 1'b0;
    tick();
  endtask

  task automatic test_addr_trunc();
    bus0.m1_req_i = 1'b1; bus0.m1_we_i = 1'b0; bus0.m1_addr_i = 16'hF010;
    for (int c = 0; c < 3; c++) begin
      tick();
      total++;
      if (bus0.m0_ack_o !== 1'b0) begin
        bad++;
        $display("FAIL trunc_m0_ack cycle %0d: got %b want 0", c, bus0.m0_ack_o);
      end
      if (c == 0) begin
        total++;
        if ({bus0.mem_addr_o, bus0.grant_o} !== {12'h010, 2'b10}) begin
          bad++;
          $display("FAIL trunc_addr: addr=%h grant=%b want 010 10", bus0.mem_addr_o, bus0.grant_o);
        end
      end
      if (c == 1) begin
        total++;
        if ({bus0.m1_ack_o, bus0.m1_rdata_o, bus0.m0_rdata_o} !== {1'b1, 16'h1234, 16'h0000}) begin
          bad++;
          $display("FAIL trunc_rdata: ack1=%b rdata1=%h rdata0=%h want 1 1234 0000",
                   bus0.m1_ack_o, bus0.m1_rdata_o, bus0.m0_rdata_o);
        end
        bus0.m1_req_i = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid();
    bus0.m1_req_i = 1'b1; bus0.m1_we_i = 1'b1; bus0.m1_addr_i = 16'h0030;
    bus0.m1_wdata_i = 16'h5555;
    tick();
    total++;
    if ({bus0.mem_we_o, bus0.grant_o} !== 3'b110) begin
      bad++;
      $display("FAIL rstmid_access: we=%b grant=%b want 1 10", bus0.mem_we_o, bus0.grant_o);
    end
    rst = 1'b1;
    bus0.m1_req_i = 1'b0;
    tick();
    rst = 1'b0;
    total++;
    if ({bus0.mem_we_o, bus0.grant_o, bus0.m1_ack_o, bus0.mem_addr_o} !== 16'd0) begin
      bad++;
      $display("FAIL rstmid_after: we=%b grant=%b ack1=%b addr=%h want 0",
               bus0.mem_we_o, bus0.grant_o, bus0.m1_ack_o, bus0.mem_addr_o);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      total++;
      if ({bus0.m1_ack_o, bus0.grant_o} !== 3'b000) begin
        bad++;
        $display("FAIL rstmid_quiet cycle %0d: ack1=%b grant=%b want 0", c, bus0.m1_ack_o,
                 bus0.grant_o);
      end
    end
    // last_grant is back at port 1, so port 0 takes the next tie.
    bus0.m0_req_i = 1'b1; bus0.m0_we_i = 1'b0;
    bus0.m1_req_i = 1'b1; bus0.m1_we_i = 1'b0;
    tick();
    total++;
    if (bus0.grant_o !== 2'b01) begin
      bad++;
      $display("FAIL rstmid_tie: got %b want 01", bus0.grant_o);
    end
    bus0.m0_req_i = 1'b0;
    bus0.m1_req_i = 1'b0;
    tick();
    tick();
    tick();
    tick();
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) begin
      ram0[a] = 16'h0000;
      ram1[a] = 16'h0000;
    end
    clear_reqs();
    test_reset();
    test_write_read();
    test_round_robin();
    test_fixed_prio();
    test_addr_trunc();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
